// File: rtl/debug_pkg.sv
// Shared types and sizing for the debug-link dump transmitter.
// DEBUG_DUMP_CHECKSUM_EN appends one XOR checksum byte to each dump.
package debug_pkg;

   localparam int DATA_WIDTH      = 32;
   localparam int DATA_WIDTH_UART = 8;
   localparam int N_REGS          = 32;
   localparam int N_MEM           = 32;
   localparam int REG_AW          = $clog2(N_REGS);
   localparam int MEM_AW          = $clog2(N_MEM);
   localparam int WORD_AW         = (REG_AW > MEM_AW) ? REG_AW : MEM_AW;
   localparam int BYTES_PER_WORD  = DATA_WIDTH / DATA_WIDTH_UART;
   localparam int BYTE_CW         = $clog2(BYTES_PER_WORD);

`ifdef DEBUG_DUMP_CHECKSUM_EN
   localparam int DUMP_BYTES = (1 + N_REGS + N_MEM) * BYTES_PER_WORD + 1;
`else
   localparam int DUMP_BYTES = (1 + N_REGS + N_MEM) * BYTES_PER_WORD;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_LOAD,
      ST_SEND,
      ST_WAIT,
      ST_CSUM,
      ST_DONE
   } state_t;

   typedef enum logic [1:0] {
      SEC_PC,
      SEC_REG,
      SEC_MEM
   } section_t;

endpackage

// File: rtl/word_serializer.sv
// Word load/shift register with byte counter; presents the current
// byte LSB first and flags the last byte of the word.
module word_serializer
   import debug_pkg::*;
(
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_load,
   input  logic [DATA_WIDTH-1:0]      i_word,
   input  logic                       i_shift,
   input  logic                       i_clear,
   output logic [DATA_WIDTH_UART-1:0] o_byte,
   output logic                       o_last_byte
);

   logic [DATA_WIDTH-1:0] word_q;
   logic [BYTE_CW-1:0]    cnt_q;

   always_ff @(posedge i_clock) begin
      if (i_reset || i_clear) begin
         word_q <= '0;
         cnt_q  <= '0;
      end else if (i_load) begin
         word_q <= i_word;
         cnt_q  <= '0;
      end else if (i_shift) begin
         word_q <= word_q >> DATA_WIDTH_UART;
         cnt_q  <= o_last_byte ? '0 : cnt_q + 1'b1;
      end
   end

   assign o_byte      = word_q[DATA_WIDTH_UART-1:0];
   assign o_last_byte = (cnt_q == BYTE_CW'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/debug_dump_tx.sv
// Debug-link dump: PC, R0..R31, MEM[0..31] as LSB-first bytes to the UART.
// DEBUG_DUMP_CHECKSUM_EN adds a trailing XOR byte (261 bytes per dump).
module debug_dump_tx
   import debug_pkg::*;
(
   input  logic                       i_clock,
   input  logic                       i_reset,
   input  logic                       i_start,
   input  logic [DATA_WIDTH-1:0]      i_pc,
   output logic [REG_AW-1:0]          o_reg_addr,
   input  logic [DATA_WIDTH-1:0]      i_reg_data,
   output logic [MEM_AW-1:0]          o_mem_addr,
   input  logic [DATA_WIDTH-1:0]      i_mem_data,
   input  logic                       i_tx_available,
   input  logic                       i_tx_done,
   output logic                       o_tx_start,
   output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
   output logic                       o_busy,
   output logic                       o_done
);

   state_t                     state_q, state_d;
   section_t                   sec_q, sec_d;
   logic [WORD_AW-1:0]         word_q, word_d;
   logic                       tx_start_q;
   logic [DATA_WIDTH_UART-1:0] tx_byte_q;
   logic                       tx_fire;
   logic [DATA_WIDTH_UART-1:0] fire_byte;
   logic                       ser_load, ser_shift, ser_clear;
   logic                       ser_last;
   logic [DATA_WIDTH_UART-1:0] ser_byte;
   logic [DATA_WIDTH-1:0]      load_word;
   logic                       csum_done;

`ifdef DEBUG_DUMP_CHECKSUM_EN
   localparam state_t AFTER_MEM = ST_CSUM;
   logic [DATA_WIDTH_UART-1:0] csum_q;
   logic                       csum_phase_q;
   assign csum_done = csum_phase_q;
`else
   localparam state_t AFTER_MEM = ST_DONE;
   assign csum_done = 1'b0;
`endif

   word_serializer u_ser (
      .i_clock     (i_clock),
      .i_reset     (i_reset),
      .i_load      (ser_load),
      .i_word      (load_word),
      .i_shift     (ser_shift),
      .i_clear     (ser_clear),
      .o_byte      (ser_byte),
      .o_last_byte (ser_last)
   );

   always_comb begin
      load_word = i_pc;
      unique case (sec_q)
         SEC_REG: load_word = i_reg_data;
         SEC_MEM: load_word = i_mem_data;
         default: load_word = i_pc;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      sec_d     = sec_q;
      word_d    = word_q;
      ser_load  = 1'b0;
      ser_shift = 1'b0;
      ser_clear = 1'b0;
      tx_fire   = 1'b0;
      fire_byte = ser_byte;
      unique case (state_q)
         ST_IDLE: if (i_start) begin
            state_d = ST_ADDR;
            sec_d   = SEC_PC;
            word_d  = '0;
         end
         ST_ADDR: state_d = ST_LOAD;
         ST_LOAD: begin
            ser_load = 1'b1;
            state_d  = ST_SEND;
         end
         ST_SEND: if (i_tx_available) begin
            tx_fire = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: if (i_tx_done) begin
            if (csum_done) begin
               state_d = ST_DONE;
            end else begin
               ser_shift = 1'b1;
               if (!ser_last) begin
                  state_d = ST_SEND;
               end else begin
                  state_d = ST_ADDR;
                  unique case (sec_q)
                     SEC_PC: begin
                        sec_d  = SEC_REG;
                        word_d = '0;
                     end
                     SEC_REG: begin
                        if (word_q == WORD_AW'(N_REGS - 1)) begin
                           sec_d  = SEC_MEM;
                           word_d = '0;
                        end else begin
                           word_d = word_q + 1'b1;
                        end
                     end
                     SEC_MEM: begin
                        if (word_q == WORD_AW'(N_MEM - 1))
                           state_d = AFTER_MEM;
                        else
                           word_d = word_q + 1'b1;
                     end
                     default: state_d = ST_IDLE;
                  endcase
               end
            end
         end
`ifdef DEBUG_DUMP_CHECKSUM_EN
         ST_CSUM: if (i_tx_available) begin
            tx_fire   = 1'b1;
            fire_byte = csum_q;
            state_d   = ST_WAIT;
         end
`endif
         ST_DONE: begin
            state_d   = ST_IDLE;
            ser_clear = 1'b1;
            sec_d     = SEC_PC;
            word_d    = '0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q    <= ST_IDLE;
         sec_q      <= SEC_PC;
         word_q     <= '0;
         tx_start_q <= 1'b0;
         tx_byte_q  <= '0;
      end else begin
         state_q    <= state_d;
         sec_q      <= sec_d;
         word_q     <= word_d;
         tx_start_q <= tx_fire;
         if (tx_fire)
            tx_byte_q <= fire_byte;
      end
   end

`ifdef DEBUG_DUMP_CHECKSUM_EN
   // Checksum byte itself is excluded from the running XOR.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         csum_q       <= '0;
         csum_phase_q <= 1'b0;
      end else if (state_q == ST_IDLE && i_start) begin
         csum_q       <= '0;
         csum_phase_q <= 1'b0;
      end else if (tx_fire) begin
         if (state_q == ST_CSUM)
            csum_phase_q <= 1'b1;
         else
            csum_q <= csum_q ^ fire_byte;
      end else if (state_q == ST_DONE) begin
         csum_phase_q <= 1'b0;
      end
   end
`endif

   assign o_reg_addr = (sec_q == SEC_REG) ? word_q[REG_AW-1:0] : '0;
   assign o_mem_addr = (sec_q == SEC_MEM) ? word_q[MEM_AW-1:0] : '0;
   assign o_tx_start = tx_start_q;
   assign o_tx_byte  = tx_byte_q;
   assign o_busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
   assign o_done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_debug_dump_tx.sv
// Bench for debug_dump_tx: randomized UART timing and data against a
// byte-list reference model of the dump.
module tb_debug_dump_tx;

   logic        i_clock = 1'b0;
   logic        i_reset;
   logic        i_start;
   logic [31:0] i_pc;
   logic [4:0]  o_reg_addr;
   logic [31:0] i_reg_data;
   logic [4:0]  o_mem_addr;
   logic [31:0] i_mem_data;
   logic        i_tx_available;
   logic        i_tx_done;
   logic        o_tx_start;
   logic [7:0]  o_tx_byte;
   logic        o_busy;
   logic        o_done;

   always #5 i_clock = ~i_clock;

   debug_dump_tx dut (
      .i_clock        (i_clock),
      .i_reset        (i_reset),
      .i_start        (i_start),
      .i_pc           (i_pc),
      .o_reg_addr     (o_reg_addr),
      .i_reg_data     (i_reg_data),
      .o_mem_addr     (o_mem_addr),
      .i_mem_data     (i_mem_data),
      .i_tx_available (i_tx_available),
      .i_tx_done      (i_tx_done),
      .o_tx_start     (o_tx_start),
      .o_tx_byte      (o_tx_byte),
      .o_busy         (o_busy),
      .o_done         (o_done)
   );

   logic [31:0] regs [32];
   logic [31:0] mem  [32];
   logic [7:0]  expq [$];
   logic [4:0]  ra_d, ma_d;
   logic [7:0]  held;
   int n_checks, n_errors;
   int idx, ndone, ucnt, stall_left, k, max_ra, max_ma;
   bit ub, stall_used, lat_chk;

   task automatic check_eq(input string tag,
                           input logic [31:0] got,
                           input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push_word(input logic [31:0] w);
      for (int b = 0; b < 4; b++) begin
         logic [7:0] v;
         v = 8'((w >> (8 * b)) & 32'hFF);
         expq.push_back(v);
      end
   endtask

   task automatic build_expected();
      logic [7:0] x;
      expq.delete();
      push_word(i_pc);
      for (int r = 0; r < 32; r++) push_word(regs[r]);
      for (int m = 0; m < 32; m++) push_word(mem[m]);
`ifdef DEBUG_DUMP_CHECKSUM_EN
      x = 8'h00;
      foreach (expq[j]) x = x ^ expq[j];
      expq.push_back(x);
`endif
   endtask

   task automatic check_idle(input string tag);
      check_eq({tag, "_busy"}, o_busy, 0);
      check_eq({tag, "_done"}, o_done, 0);
      check_eq({tag, "_start"}, o_tx_start, 0);
      check_eq({tag, "_byte"}, o_tx_byte, 0);
      check_eq({tag, "_raddr"}, o_reg_addr, 0);
      check_eq({tag, "_maddr"}, o_mem_addr, 0);
   endtask

   task automatic cycle(input int stall_at);
      @(negedge i_clock);
      k++;
      i_start   = 1'b0;
      i_tx_done = 1'b0;
      if (stall_left > 0) begin
         check_eq("stall_start", o_tx_start, 0);
         check_eq("stall_byte", o_tx_byte, held);
         stall_left--;
         if (stall_left == 40) i_tx_done = 1'b1;
         if (stall_left == 30) i_start = 1'b1;
      end else if (o_tx_start) begin
         if (lat_chk && idx == 0) check_eq("latency", k, 4);
         if (idx < expq.size())
            check_eq("tx_byte", o_tx_byte, expq[idx]);
         else
            check_eq("extra_byte", idx, expq.size());
         idx++;
         ub   = 1'b1;
         ucnt = $urandom_range(1, 3);
         held = o_tx_byte;
      end else if (ub) begin
         check_eq("hold_byte", o_tx_byte, held);
         ucnt--;
         if (ucnt == 0) begin
            i_tx_done = 1'b1;
            ub = 1'b0;
         end
      end
      if (!ub && idx == stall_at && !stall_used) begin
         stall_used = 1'b1;
         stall_left = 50;
      end
      if (o_done) begin
         ndone++;
         check_eq("done_pos", idx, expq.size());
         check_eq("done_idle", ub, 0);
      end
      if (stall_left == 0 && idx > 0 && idx < expq.size() - 1 &&
          $urandom_range(0, 99) == 0)
         i_start = 1'b1;
      if (o_busy && int'(o_reg_addr) > max_ra) max_ra = int'(o_reg_addr);
      if (o_busy && int'(o_mem_addr) > max_ma) max_ma = int'(o_mem_addr);
      i_tx_available = !ub && stall_left == 0;
      i_reg_data = regs[ra_d];
      i_mem_data = mem[ma_d];
      ra_d = o_reg_addr;
      ma_d = o_mem_addr;
   endtask

   task automatic dump(input int stall_at, input int abort_at,
                       input bit lat);
      bit fin;
      int tail;
      build_expected();
      idx = 0; ndone = 0; ub = 0; k = 0;
      stall_used = 0; stall_left = 0;
      max_ra = 0; max_ma = 0; tail = 0; fin = 0;
      lat_chk = lat;
      @(negedge i_clock);
      i_tx_available = 1'b1;
      i_start = 1'b1;
      for (int c = 0; c < 20000 && !fin; c++) begin
         cycle(stall_at);
         if (k == 1) check_eq("busy", o_busy, 1);
         if (abort_at >= 0 && idx == abort_at) begin
            i_reset = 1'b1;
            i_tx_done = 1'b0;
            ub = 1'b0;
            fin = 1'b1;
         end
         if (ndone > 0) tail++;
         if (tail == 6) fin = 1'b1;
      end
      if (!fin) check_eq("timeout", 0, 1);
      if (abort_at >= 0) begin
         @(negedge i_clock);
         check_idle("abort");
         i_reset = 1'b0;
         i_tx_available = 1'b1;
      end else begin
         check_eq("byte_count", idx, expq.size());
         check_eq("done_count", ndone, 1);
         check_eq("reg_addr_max", max_ra, 31);
         check_eq("mem_addr_max", max_ma, 31);
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      i_reset = 1'b1;
      i_start = 1'b0;
      i_tx_available = 1'b1;
      i_tx_done = 1'b0;
      i_pc = 32'h0000_0040;
      i_reg_data = '0;
      i_mem_data = '0;
      ra_d = '0;
      ma_d = '0;
      for (int n = 0; n < 32; n++) begin
         regs[n] = 32'(n) * 32'h0101_0101;
         mem[n]  = 32'hA500_0000 + 32'(n);
      end
      repeat (3) @(negedge i_clock);
      check_idle("reset");
      i_reset = 1'b0;

      dump(6, -1, 1'b1);

      i_pc = $urandom;
      for (int n = 0; n < 32; n++) begin
         regs[n] = $urandom;
         mem[n]  = $urandom;
      end
      dump(-1, 100, 1'b0);
      dump(-1, -1, 1'b0);

      for (int t = 0; t < 3; t++) begin
         i_pc = $urandom;
         for (int n = 0; n < 32; n++) begin
            regs[n] = $urandom;
            mem[n]  = $urandom;
         end
         dump($urandom_range(1, 259), -1, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
